input_ctrl: RTL
===============

// Module: input_ctrl
// PURPOSE
//  Parametrised user-input unit for the processor I/O path; successor of the simple switch-input block.
//  On a control-unit read request it stalls the core and waits for one clean, debounced button press.
//  It then captures the synchronised switch word, widens it to the register width and pulses a valid flag.
//  Sits between board switches/button and the register-file write mux; haltIn feeds the clock-divider hold.
// PARAMETERS
//  DATA_W        18      switch bus width
//  OUT_W         32      output width to register file; OUT_W >= DATA_W
//  SIGN_EXT      0       0: zero-extend switch word to OUT_W; 1: sign-extend from bit DATA_W-1
//  SYNC_STAGES   2       flop stages on switch and btn inputs; >= 2
//  DEBOUNCE_CYC  250000  consecutive stable cycles before debounced btn changes (5 ms @ 50 MHz); >= 1
// PORTS
//  clock         in   1        single system clock, all state on rising edge
//  reset_n       in   1        synchronous, active-low reset
//  switch        in   DATA_W   asynchronous board switches
//  btn           in   1        asynchronous confirm button, 1 = pressed, bounces
//  escreveInput  in   1        control-unit read-input request, level, held until input_valid
//  haltIn        out  1        1 = hold processor (clock divider) while waiting for the user
//  saida         out  OUT_W    last captured, extended switch value
//  input_valid   out  1        one-cycle pulse: saida just updated, UC may write register
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): state=IDLE; all sync flops, debounce counter, btn_db = 0; saida=0, input_valid=0.
//   haltIn forced 0 while reset_n=0, regardless of escreveInput.
//  Sync: switch and btn each pass SYNC_STAGES flops -> sw_s, btn_s.
//  Debounce: counter increments while btn_s != btn_db, clears whenever btn_s == btn_db.
//   btn_db toggles on the edge where btn_s has differed for DEBOUNCE_CYC consecutive cycles; counter clears there.
//   btn_press = btn_db & ~btn_db_q (one-cycle rising-edge pulse). Counter width $clog2(DEBOUNCE_CYC+1).
//  FSM states IDLE, ARM, WAIT_PRESS, DONE:
//   IDLE:       escreveInput=1 -> ARM.
//   ARM:        btn_db=0 -> WAIT_PRESS. A button already held at request time is never accepted; release required.
//   WAIT_PRESS: btn_press=1 -> DONE; same edge saida <= ext(sw_s), ext per SIGN_EXT.
//   DONE:       input_valid=1 (this state only, exactly 1 cycle) -> IDLE unconditionally.
//   Abort: escreveInput=0 in ARM or WAIT_PRESS -> IDLE next edge; saida unchanged; no input_valid.
//   escreveInput still 1 in IDLE after DONE starts a new transaction (new release + press needed).
//  haltIn = reset_n & escreveInput & (state != DONE). Combinational, so the stall starts in the request cycle
//   and drops in the valid cycle and in the abort cycle.
//  Latency: input_valid rises 1 cycle after btn_press; btn_press follows a clean btn edge by
//   SYNC_STAGES + DEBOUNCE_CYC + 1 cycles.
//  saida holds its value between transactions; it is never zeroed except by reset.
//  Bounce shorter than DEBOUNCE_CYC never changes btn_db, so at most one capture per transaction.
//  switch changing during the wait is irrelevant; only sw_s at the btn_press edge is captured.
// STRUCTURE
//  Package io_pkg: state enum (IDLE, ARM, WAIT_PRESS, DONE) as localparam 2-bit codes and the ext() width function.
//  Sub-module btn_debounce (params SYNC_STAGES, DEBOUNCE_CYC; ports clock, reset_n, raw, level, rise).
//  Top holds the switch synchroniser, FSM, capture register and haltIn logic.
// TESTING  (DEBOUNCE_CYC=4, SYNC_STAGES=2, DATA_W=18, OUT_W=32 unless stated)
//  1 reset_n=0 for 3 cycles with escreveInput=1, btn=1 -> haltIn=0, saida=0, input_valid=0 throughout.
//  2 switch=18'h2A5F3, escreveInput=1, btn high for 10 cycles -> haltIn=1 until the valid cycle;
//    saida=32'h0002A5F3; input_valid high exactly 1 cycle, 8 cycles after btn rises.
//  3 btn toggling every 2 cycles for 12 cycles, then stable 1 -> exactly one input_valid after stabilising.
//  4 btn held 1 before escreveInput rises -> no capture while held; release then new press -> one input_valid.
//  5 escreveInput dropped in WAIT_PRESS -> haltIn 0 same cycle; saida unchanged; later press gives no input_valid.
//  6 SIGN_EXT=1, switch=18'h20001, press -> saida=32'hFFFE0001; SIGN_EXT=0 -> 32'h00020001.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: shared FSM state codes and switch-word extension for the input unit.
package io_pkg;
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARM        = 2'd1,
        WAIT_PRESS = 2'd2,
        DONE       = 2'd3
    } state_t;
    localparam int EXT_MAX = 64;
    // Extends the low dw bits of v to EXT_MAX bits; callers truncate to their own width.
    function automatic logic [EXT_MAX-1:0] ext(input logic [EXT_MAX-1:0] v, input int dw, input logic sgn);
        logic [EXT_MAX-1:0] hi;
        logic msb;
        hi = ~(EXT_MAX'(0)) << dw;
        msb = |(v & (EXT_MAX'(1) << (dw - 1)));
        return (v & ~hi) | ((sgn && msb) ? hi : EXT_MAX'(0));
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncing button and emits a debounced level plus a one-cycle rise pulse.
module btn_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0] cnt;
    logic level_q;
    logic btn_s;
    assign btn_s = sync[SYNC_STAGES-1];
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], raw};
            level_q <= level;
            if (btn_s == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYC)) begin
                cnt   <= '0;
                level <= ~level;
            end else
                cnt <= cnt + 1'b1;
        end
    end
    assign rise = level & ~level_q;
endmodule

// File: rtl/input_ctrl.sv
// input_ctrl: stalls the core on a read request until one debounced button press,
// then captures the synchronised switch word, extends it and pulses input_valid.
module input_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W       = 18,
    parameter int OUT_W        = 32,
    parameter int SIGN_EXT     = 0,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] switch,
    input  logic              btn,
    input  logic              escreveInput,
    output logic              haltIn,
    output logic [OUT_W-1:0]  saida,
    output logic              input_valid
);
    state_t state, nxt;
    logic [DATA_W-1:0] sw_sync [SYNC_STAGES];
    logic [DATA_W-1:0] sw_s;
    logic btn_db, btn_press;

    btn_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    (btn),
        .level  (btn_db),
        .rise   (btn_press)
    );

    assign sw_s = sw_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
            state <= IDLE;
            saida <= '0;
        end else begin
            sw_sync[0] <= switch;
            for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
            state <= nxt;
            if (state == WAIT_PRESS && escreveInput && btn_press)
                saida <= OUT_W'(ext(EXT_MAX'(sw_s), DATA_W, SIGN_EXT != 0));
        end
    end

    // A button already down at request time keeps ARM waiting until it is released.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:       nxt = escreveInput ? ARM : IDLE;
            ARM:        nxt = !escreveInput ? IDLE : (btn_db ? ARM : WAIT_PRESS);
            WAIT_PRESS: nxt = !escreveInput ? IDLE : (btn_press ? DONE : WAIT_PRESS);
            default:    nxt = IDLE;
        endcase
    end

    assign input_valid = state == DONE;
    assign haltIn = reset_n & escreveInput & (state != DONE);
endmodule
